// File: rtl/synth_pkg.sv
// Shared definitions for the phase accumulator voice engine: bank count,
// data widths, the per-voice sample rate used to derive tuning words, and the
// command decode type. The optional voice-stealing feature is selected by
// defining VOICE_STEAL_EN at build time.
package synth_pkg;

  // Number of time-multiplexed voice slots.
  localparam int NBANKS  = 10;
  // Width of the phase value handed to the sine stage.
  localparam int PHASE_W = 16;
  // MIDI note number width.
  localparam int MIDI_W  = 7;
  // Default phase accumulator width.
  localparam int ACC_W   = 32;
  // Number of MIDI notes covered by the tuning table.
  localparam int NOTES   = 128;

  // Rate at which one slot is revisited, i.e. f_clk_en / NBANKS, in Hz.
  localparam real F_SAMPLE_HZ = 48000.0;

  // What an accepted command does to the slot table this cycle.
  typedef enum logic [2:0] {
    ACT_NONE,    // no command, or note-off that matched nothing
    ACT_RETRIG,  // note-on hitting an already sounding note
    ACT_ALLOC,   // note-on taking the lowest free slot
    ACT_FULL,    // note-on with every slot busy
    ACT_OFF      // note-off releasing every matching slot
  } cmd_act_e;

  // Slot pointer width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/midi_tuning_lut.sv
// Combinational MIDI-note to phase-increment table. Entry m holds
// round(f_note(m) * 2^ACC_W / F_SAMPLE_HZ) with f_note(m) = 440 Hz *
// 2^((m-69)/12); the table is folded to constants at elaboration.
// Build option VOICE_STEAL_EN has no effect here.
module midi_tuning_lut
  import synth_pkg::*;
#(
  parameter int ACC_W = synth_pkg::ACC_W
) (
  input  logic [MIDI_W-1:0] midi_i,
  output logic [ACC_W-1:0]  tw_o
);

  logic [ACC_W-1:0] table_w [NOTES];

  for (genvar gi = 0; gi < NOTES; gi++) begin : g_entry
    // Equal-tempered frequency relative to A4 = 440 Hz.
    localparam real F_NOTE = 440.0 * (2.0 ** ((gi - 69) / 12.0));
    // Increment per slot visit; real-to-integer cast rounds to nearest.
    localparam real TW_R   = F_NOTE * (2.0 ** ACC_W) / F_SAMPLE_HZ;
    localparam longint TW_L = longint'(TW_R);
    localparam logic [ACC_W-1:0] TW = ACC_W'(TW_L);
    assign table_w[gi] = TW;
  end

  assign tw_o = table_w[midi_i];

endmodule

// File: rtl/phase_accum_p.sv
// Time-multiplexed phase accumulator for NBANKS voices. A round-robin
// pointer visits one slot per enabled cycle, registers that slot's phase,
// note and active flag, then advances its accumulator by the note's tuning
// word. Note-on/off commands allocate, retrigger and release slots in
// parallel with servicing; a command on the serviced slot wins over the
// accumulate. Build option VOICE_STEAL_EN makes a note-on with all slots
// busy overwrite a rotating victim slot instead of being dropped.
module phase_accum_p
  import synth_pkg::*;
#(
  parameter int NBANKS = synth_pkg::NBANKS,
  parameter int ACC_W  = synth_pkg::ACC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               i_cmd_valid,
  input  logic               i_cmd_on,
  input  logic [MIDI_W-1:0]  i_cmd_midi,
  output logic               o_cmd_ready,
  output logic [PHASE_W-1:0] o_phase,
  output logic [MIDI_W-1:0]  o_midi,
  output logic               o_valid,
  output logic               o_overflow
);

  localparam int IDX_W = idx_width(NBANKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBANKS - 1);

  // Slot table and service pointer.
  logic [IDX_W-1:0]  v_idx_q, v_idx_d;
  logic              active_q [NBANKS];
  logic              active_d [NBANKS];
  logic [MIDI_W-1:0] midi_q   [NBANKS];
  logic [MIDI_W-1:0] midi_d   [NBANKS];
  logic [ACC_W-1:0]  acc_q    [NBANKS];
  logic [ACC_W-1:0]  acc_d    [NBANKS];

  // Registered outputs.
  logic [PHASE_W-1:0] phase_q;
  logic [MIDI_W-1:0]  omidi_q;
  logic               valid_q;
  logic               overflow_q;

  // Command decode.
  logic              cmd_accept;
  logic [NBANKS-1:0] match_vec;
  logic              match_any;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  cmd_act_e          act;

  // Tuning word of the slot being serviced.
  logic [ACC_W-1:0]  tw_cur;

`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]  steal_q, steal_d;
`endif

  // Commands are taken exactly on enabled cycles; nothing is taken in reset.
  assign o_cmd_ready = clk_en & rst_n;
  assign cmd_accept  = i_cmd_valid & clk_en;

  // Per-slot note comparison; only sounding slots can match.
  for (genvar gi = 0; gi < NBANKS; gi++) begin : g_match
    assign match_vec[gi] = active_q[gi] && (midi_q[gi] == i_cmd_midi);
  end
  assign match_any = |match_vec;

  // Lowest-index free slot: scan downward so the lowest wins last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Classify the accepted command against the current slot table.
  always_comb begin
    act = ACT_NONE;
    if (cmd_accept) begin
      if (i_cmd_on) begin
        if (match_any) begin
          act = ACT_RETRIG;
        end else if (free_found) begin
          act = ACT_ALLOC;
        end else begin
          act = ACT_FULL;
        end
      end else if (match_any) begin
        act = ACT_OFF;
      end
    end
  end

  midi_tuning_lut #(
    .ACC_W (ACC_W)
  ) u_lut (
    .midi_i (midi_q[v_idx_q]),
    .tw_o   (tw_cur)
  );

  // Next slot state: accumulate the serviced slot, then let the command
  // overwrite whatever it touches so a same-slot accumulate is discarded.
  always_comb begin
    v_idx_d  = v_idx_q;
    active_d = active_q;
    midi_d   = midi_q;
    acc_d    = acc_q;
`ifdef VOICE_STEAL_EN
    steal_d  = steal_q;
`endif
    if (clk_en) begin
      v_idx_d = (v_idx_q == LAST_IDX) ? '0 : v_idx_q + 1'b1;
      if (active_q[v_idx_q]) begin
        acc_d[v_idx_q] = acc_q[v_idx_q] + tw_cur;
      end
    end
    case (act)
      ACT_RETRIG: begin
        for (int i = 0; i < NBANKS; i++) begin
          if (match_vec[i]) begin
            acc_d[i] = '0;
          end
        end
      end
      ACT_ALLOC: begin
        active_d[free_idx] = 1'b1;
        midi_d[free_idx]   = i_cmd_midi;
        acc_d[free_idx]    = '0;
      end
      ACT_FULL: begin
`ifdef VOICE_STEAL_EN
        active_d[steal_q] = 1'b1;
        midi_d[steal_q]   = i_cmd_midi;
        acc_d[steal_q]    = '0;
        steal_d = (steal_q == LAST_IDX) ? '0 : steal_q + 1'b1;
`endif
      end
      ACT_OFF: begin
        for (int i = 0; i < NBANKS; i++) begin
          if (match_vec[i]) begin
            active_d[i] = 1'b0;
            midi_d[i]   = '0;
            acc_d[i]    = '0;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Slot table and pointer advance only on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_idx_q <= '0;
      for (int i = 0; i < NBANKS; i++) begin
        active_q[i] <= 1'b0;
        midi_q[i]   <= '0;
        acc_q[i]    <= '0;
      end
    end else if (clk_en) begin
      v_idx_q  <= v_idx_d;
      active_q <= active_d;
      midi_q   <= midi_d;
      acc_q    <= acc_d;
    end
  end

`ifdef VOICE_STEAL_EN
  // Victim pointer for stealing, rotates once per steal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steal_q <= '0;
    end else if (clk_en) begin
      steal_q <= steal_d;
    end
  end
`endif

  // Output stage shows the serviced slot's pre-command state; the overflow
  // pulse is re-evaluated every edge so it never outlives one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      omidi_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= (act == ACT_FULL);
      if (clk_en) begin
        valid_q <= active_q[v_idx_q];
        phase_q <= active_q[v_idx_q] ? acc_q[v_idx_q][ACC_W-1 -: PHASE_W] : '0;
        omidi_q <= active_q[v_idx_q] ? midi_q[v_idx_q] : '0;
      end
    end
  end

  assign o_phase    = phase_q;
  assign o_midi     = omidi_q;
  assign o_valid    = valid_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_phase_accum_p.sv
// Self-checking bench for phase_accum_p: directed scenarios plus a random
// command stream, each enabled edge checked against a slot-table model.
module tb_phase_accum_p;
  import synth_pkg::*;

  localparam int N = synth_pkg::NBANKS;
  localparam int AW = synth_pkg::ACC_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        i_cmd_on = 1'b0;
  logic [6:0]  i_cmd_midi = '0;
  logic        o_cmd_ready;
  logic [15:0] o_phase;
  logic [6:0]  o_midi;
  logic        o_valid;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;

  // Reference slot table.
  bit          m_active [N];
  int          m_midi   [N];
  logic [AW-1:0] m_acc  [N];
  int          m_vidx;
  int          m_steal;
  logic [15:0] e_phase;
  int          e_midi;
  bit          e_valid;
  bit          e_ovf;

  phase_accum_p #(
    .NBANKS (N),
    .ACC_W  (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_on    (i_cmd_on),
    .i_cmd_midi  (i_cmd_midi),
    .o_cmd_ready (o_cmd_ready),
    .o_phase     (o_phase),
    .o_midi      (o_midi),
    .o_valid     (o_valid),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  // Equal-tempered tuning word: f * 2^AW / sample rate, rounded.
  function automatic longint ref_tw(input int m);
    real f;
    real t;
    f = 440.0 * (2.0 ** ((m - 69) / 12.0));
    t = f * (2.0 ** AW) / F_SAMPLE_HZ;
    return longint'(t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 0;
      m_midi[i]   = 0;
      m_acc[i]    = '0;
    end
    m_vidx = 0; m_steal = 0;
    e_phase = '0; e_midi = 0; e_valid = 0; e_ovf = 0;
  endtask

  // One enabled edge of the slot table, straight from the note rules.
  task automatic model_edge(input bit en, input bit v, input bit on, input int md);
    bit hit;
    int fr;
    e_ovf = 0;
    if (!en) return;
    e_valid = m_active[m_vidx];
    e_phase = m_active[m_vidx] ? m_acc[m_vidx][AW-1 -: 16] : 16'h0;
    e_midi  = m_active[m_vidx] ? m_midi[m_vidx] : 0;
    if (m_active[m_vidx]) m_acc[m_vidx] = m_acc[m_vidx] + AW'(ref_tw(m_midi[m_vidx]));
    if (v) begin
      hit = 0;
      for (int i = 0; i < N; i++)
        if (m_active[i] && m_midi[i] == md) begin
          hit = 1;
          if (on) m_acc[i] = '0;
          else begin m_active[i] = 0; m_midi[i] = 0; m_acc[i] = '0; end
        end
      if (on && !hit) begin
        fr = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_active[i]) fr = i;
        if (fr >= 0) begin
          m_active[fr] = 1; m_midi[fr] = md; m_acc[fr] = '0;
        end else begin
          e_ovf = 1;
`ifdef VOICE_STEAL_EN
          m_active[m_steal] = 1; m_midi[m_steal] = md; m_acc[m_steal] = '0;
          m_steal = (m_steal + 1) % N;
`endif
        end
      end
    end
    m_vidx = (m_vidx + 1) % N;
  endtask

  // Drive one cycle, check ready before the edge and outputs after it.
  task automatic step(input bit en, input bit v, input bit on, input int md);
    clk_en = en; i_cmd_valid = v; i_cmd_on = on; i_cmd_midi = 7'(md);
    #1;
    chk("cmd_ready", 32'(o_cmd_ready), 32'(en));
    @(posedge clk);
    model_edge(en, v, on, md);
    #1;
    chk("phase", 32'(o_phase), 32'(e_phase));
    chk("midi", 32'(o_midi), 32'(e_midi));
    chk("valid", 32'(o_valid), 32'(e_valid));
    chk("overflow", 32'(o_overflow), 32'(e_ovf));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_phase"}, 32'(o_phase), 32'h0);
    chk({tag, "_midi"}, 32'(o_midi), 32'h0);
    chk({tag, "_valid"}, 32'(o_valid), 32'h0);
    chk({tag, "_ovf"}, 32'(o_overflow), 32'h0);
    chk({tag, "_ready"}, 32'(o_cmd_ready), 32'h0);
  endtask

  initial begin
    int pool [7] = '{60, 61, 62, 63, 64, 65, 127};
    model_reset();

    // Reset state, with a command presented that must be dropped.
    clk_en = 1; i_cmd_valid = 1; i_cmd_on = 1; i_cmd_midi = 7'd50;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;

    // Single note 69 in slot 0, others silent, phase advancing per turn.
    step(1, 1, 1, 69);
    idle(35);

    // Note 64 twice: one slot, retriggered; then released.
    step(1, 1, 1, 64);
    idle(13);
    step(1, 1, 1, 64);
    idle(12);
    step(1, 1, 1, 72);
    step(1, 0, 0, 64);
    idle(12);

    // Highest note wraps the accumulator within a few turns.
    step(1, 1, 1, 127);
    idle(60);

    // Asynchronous reset mid-stream with three slots sounding.
    #2;
    rst_n = 0;
    #1;
    chk_zero("midrst");
    model_reset();
    clk_en = 1; i_cmd_valid = 1; i_cmd_on = 1; i_cmd_midi = 7'd40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    idle(N + 2);

    // Fill all slots, then one more note-on.
    for (int m = 60; m <= 69; m++) step(1, 1, 1, m);
    step(1, 1, 1, 70);
    idle(2 * N);
    for (int m = 60; m <= 70; m++) step(1, 1, 0, m);
    idle(N);

    // One-in-three enable duty; commands during idle cycles are ignored.
    step(1, 1, 1, 62);
    step(1, 1, 1, 66);
    for (int k = 0; k < 90; k++) step(k % 3 == 0, k % 7 == 1, 1, 61);

    // Random command stream.
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, pool[$urandom_range(0, 6)]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_accum_p.md
PHASE_ACCUM_P -- requirements
Module: phase_accum_p

Interface
REQ-001 SHALL have parameter NBANKS, default 10, number of time-multiplexed voice slots.
REQ-002 SHALL have parameter ACC_W, default 32, phase accumulator width; top 16 bits are the output phase.
REQ-003 SHALL have port clk  in  1  single clock; all state on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port clk_en  in  1  global advance strobe; state is frozen when low.
REQ-006 SHALL have port i_cmd_valid  in  1  note command present.
REQ-007 SHALL have port i_cmd_on  in  1  1 = note-on, 0 = note-off.
REQ-008 SHALL have port i_cmd_midi  in  7  MIDI note number of the command.
REQ-009 SHALL have port o_cmd_ready  out  1  command accepted this cycle; equals clk_en while out of reset.
REQ-010 SHALL have port o_phase  out  16  phase for the sine stage.
REQ-011 SHALL have port o_midi  out  7  note of the serviced slot.
REQ-012 SHALL have port o_valid  out  1  serviced slot is active.
REQ-013 SHALL have port o_overflow  out  1  one-cycle pulse when a note-on finds no free slot.

Function
REQ-014 SHALL keep per slot: active bit, 7-bit midi, ACC_W accumulator, and a round-robin slot pointer v_idx that wraps NBANKS-1 -> 0 on every clk_en cycle.
REQ-015 SHALL, on each clk_en edge, register o_phase = acc[v_idx][ACC_W-1:ACC_W-16], o_midi = midi[v_idx], o_valid = active[v_idx]; latency is 1 cycle from slot selection; each slot is output once per NBANKS enabled cycles.
REQ-016 SHALL, for an active slot, update acc[v_idx] <= acc[v_idx] + tuning_word(midi[v_idx]) modulo 2^ACC_W after output; wrap is silent and o_valid stays 1.
REQ-017 SHALL drive o_phase = 0 and o_midi = 0 for an inactive slot and leave its accumulator at 0.
REQ-018 SHALL, on an accepted note-on whose midi matches an active slot, zero that slot's accumulator (retrigger) without allocating a new slot.
REQ-019 SHALL, on an accepted note-on with no match, allocate the lowest-index inactive slot, set midi, and zero the accumulator.
REQ-020 SHALL, on an accepted note-off, clear every active slot whose midi matches; a note-off with no match is ignored.
REQ-021 SHALL, when a command targets the slot being serviced in the same cycle, output the pre-command state and apply the command state afterwards, so the accumulate is discarded.
REQ-022 SHALL hold all state and outputs unchanged, with o_overflow = 0, while clk_en is low.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously clear every slot, set v_idx = 0, and drive o_phase = 0, o_midi = 0, o_valid = 0, o_overflow = 0, o_cmd_ready = 0.
REQ-024 SHALL drop any command presented during reset; the first enabled edge after release services slot 0.

Configuration
REQ-025 SHALL, with VOICE_STEAL_EN defined, have a note-on with all slots active overwrite the slot pointed to by a steal pointer, which then advances modulo NBANKS; o_overflow is still pulsed.
REQ-026 SHALL, without VOICE_STEAL_EN, drop such a note-on, leave all slots unchanged, and pulse o_overflow.

Structure
REQ-027 SHALL take NBANKS, PHASE_W = 16, MIDI_W = 7, and the default ACC_W from shared package synth_pkg.
REQ-028 SHALL instantiate sub-module midi_tuning_lut, a combinational 128-entry table giving round(f_note * 2^ACC_W / (f_clk_en / NBANKS)).

Verification
REQ-029 SHALL cover: reset, then note-on midi 69 -> slot 0 active; its o_phase rises by LUT[69] >> 16 every 10 enabled cycles; all other slots have o_valid = 0.
REQ-030 SHALL cover: accumulator preset near 0xFFFF_FF00 plus one increment -> o_phase wraps to a small value with o_valid held at 1.
REQ-031 SHALL cover: 10 note-ons (midi 60..69), then note-on 70 -> o_overflow pulses once; slots unchanged without VOICE_STEAL_EN; slot 0 becomes midi 70 with it.
REQ-032 SHALL cover: note-on 64 twice -> one slot only, accumulator zeroed at the second command; note-off 64 -> o_valid = 0 at that slot's next turn.
REQ-033 SHALL cover: clk_en toggled 1/3 duty -> outputs identical to the continuous-enable sequence, only spread out in time.
REQ-034 SHALL cover: rst_n asserted mid-stream with 3 active slots -> all outputs 0 immediately and no slots active after release.
